ft_recovery_ctrl: RTL and testbench

FT_RECOVERY_CTRL -- requirements
Module: ft_recovery_ctrl

---
 rtl/ft_pkg.sv | 21 ++
 rtl/ft_recovery_ctrl.sv | 148 ++++++++++++++
 tb/tb_ft_recovery_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft_pkg.sv
// Shared definitions for the lockstep fault-tolerance blocks: FSM state
// encoding and default register-file geometry.
package ft_pkg;

    localparam int FT_ADDR_WIDTH = 5;
    localparam int FT_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_RESTORE = 3'd2,
        ST_PCRST   = 3'd3,
        ST_FATAL   = 3'd4
    } ft_state_e;

    // A recovery is in flight in every state except the two resting ones.
    function automatic logic state_is_recovering(input ft_state_e s);
        return (s == ST_HALT) || (s == ST_RESTORE) || (s == ST_PCRST);
    endfunction

endpackage

// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery controller: on a core mismatch it stalls both cores, copies
// the golden shadow register file into both cores and reloads their PC.
module ft_recovery_ctrl
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH   = FT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = FT_DATA_WIDTH,
    parameter int HALT_TIMEOUT = 16,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  error_i,
    input  logic                  halted_a_i,
    input  logic                  halted_b_i,
    output logic                  halt_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  pc_restore_o,
    output logic                  recovering_o,
    output logic                  fatal_o,
    output logic [CNT_WIDTH-1:0]  recovery_cnt_o
);

    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int TMO_BITS   = $clog2(HALT_TIMEOUT + 1);
    localparam int CTR_W      = (ADDR_WIDTH + 1 > TMO_BITS) ? ADDR_WIDTH + 1 : TMO_BITS;

    localparam logic [CTR_W-1:0]     LAST_RD   = CTR_W'(DEPTH - 1);
    localparam logic [CTR_W-1:0]     LAST_WR   = CTR_W'(DEPTH);
    localparam logic [CTR_W-1:0]     HALT_LAST = CTR_W'(HALT_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    ft_state_e state_q, state_d;

    // One counter serves both the halt timeout and the restore address walk.
    logic [CTR_W-1:0] ctr_q, ctr_d;

    logic                  halt_d;
    logic                  recovering_d;
    logic                  fatal_d;
    logic                  pc_restore_d;
    logic                  wb_we_d;
    logic [ADDR_WIDTH-1:0] wb_addr_d;
    logic [ADDR_WIDTH-1:0] rf_raddr_d;
    logic [CNT_WIDTH-1:0]  recovery_cnt_d;
    logic                  retry_ok;

    assign retry_ok = int'(recovery_cnt_o) < MAX_RETRY;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;

        case (state_q)
            ST_IDLE: begin
                if (error_i) begin
                    ctr_d   = '0;
                    state_d = retry_ok ? ST_HALT : ST_FATAL;
                end
            end

            ST_HALT: begin
                if (halted_a_i && halted_b_i) begin
                    ctr_d   = '0;
                    state_d = ST_RESTORE;
                end else if (ctr_q == HALT_LAST) begin
                    state_d = ST_FATAL;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end

            // Cycle k reads address k and writes address k-1; one extra cycle
            // drains the final read, after which the walk stops for good.
            ST_RESTORE: begin
                if (ctr_q == LAST_WR) begin
                    state_d = ST_PCRST;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end

            ST_PCRST: state_d = ST_IDLE;

            ST_FATAL: state_d = ST_FATAL;

            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the next cycle, so every port comes straight from a flop.
    always_comb begin
        halt_d         = (state_d != ST_IDLE);
        recovering_d   = state_is_recovering(state_d);
        fatal_d        = (state_d == ST_FATAL);
        pc_restore_d   = (state_d == ST_PCRST);
        wb_we_d        = (state_d == ST_RESTORE) && (state_q == ST_RESTORE);
        wb_addr_d      = wb_we_d ? ctr_q[ADDR_WIDTH-1:0] : '0;
        rf_raddr_d     = rf_raddr_o;
        recovery_cnt_d = recovery_cnt_o;

        if ((state_d == ST_RESTORE) && (ctr_d <= LAST_RD)) begin
            rf_raddr_d = ctr_d[ADDR_WIDTH-1:0];
        end

        if ((state_d == ST_PCRST) && (state_q == ST_RESTORE) && (recovery_cnt_o != CNT_MAX)) begin
            recovery_cnt_d = recovery_cnt_o + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            ctr_q          <= '0;
            halt_o         <= 1'b0;
            recovering_o   <= 1'b0;
            fatal_o        <= 1'b0;
            pc_restore_o   <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_addr_o      <= '0;
            rf_raddr_o     <= '0;
            recovery_cnt_o <= '0;
        end else begin
            state_q        <= state_d;
            ctr_q          <= ctr_d;
            halt_o         <= halt_d;
            recovering_o   <= recovering_d;
            fatal_o        <= fatal_d;
            pc_restore_o   <= pc_restore_d;
            wb_we_o        <= wb_we_d;
            wb_addr_o      <= wb_addr_d;
            rf_raddr_o     <= rf_raddr_d;
            recovery_cnt_o <= recovery_cnt_d;
        end
    end

    // The shadow file answers one cycle after the registered read address, so
    // its data lines up with the registered write strobe and is only gated here.
    assign wb_data_o = wb_we_o ? rf_rdata_i : '0;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Self-checking bench for ft_recovery_ctrl: directed recovery scenarios with
// randomized shadow data and halt timing, checked against a behavioural model.
module tb_ft_recovery_ctrl;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int HT    = 16;
    localparam int MR    = 3;
    localparam int CW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int BUDGET = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          error;
    logic          halted_a;
    logic          halted_b;
    logic          halt;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata = '0;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          pc_restore;
    logic          recovering;
    logic          fatal;
    logic [CW-1:0] recovery_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] shadow [DEPTH];
    int            wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            pc_pulses;

    ft_recovery_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .HALT_TIMEOUT(HT),
        .MAX_RETRY   (MR),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .error_i       (error),
        .halted_a_i    (halted_a),
        .halted_b_i    (halted_b),
        .halt_o        (halt),
        .rf_raddr_o    (rf_raddr),
        .rf_rdata_i    (rf_rdata),
        .wb_we_o       (wb_we),
        .wb_addr_o     (wb_addr),
        .wb_data_o     (wb_data),
        .pc_restore_o  (pc_restore),
        .recovering_o  (recovering),
        .fatal_o       (fatal),
        .recovery_cnt_o(recovery_cnt)
    );

    always #5 clk = ~clk;

    // Shadow register file: synchronous read, data valid the cycle after the address.
    always @(posedge clk) rf_rdata <= shadow[rf_raddr];

    // Write/pulse monitor sampling away from the active edge.
    always @(negedge clk) begin
        if (wb_we) begin
            wr_addr_q.push_back(int'(wb_addr));
            wr_data_q.push_back(wb_data);
        end
        if (pc_restore) pc_pulses <= pc_pulses + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        pc_pulses = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        error = 1'b0;
        halted_a = 1'b0;
        halted_b = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_shadow(input bit pattern);
        for (int i = 0; i < DEPTH; i++)
            shadow[i] = pattern ? (32'hA5A5_0000 + DW'(i)) : DW'($urandom);
    endtask

    // One error event; cores report halted on HALT cycle halt_delay (0-based).
    task automatic run_recovery(input int halt_delay, input bit hold_err,
                                output int end_n, output int first_we_n);
        int  n;
        bit  done;
        clear_log();
        error = 1'b1;
        n = 0;
        done = 1'b0;
        first_we_n = -1;
        while (!done && n < BUDGET) begin
            tick();
            n++;
            if (!hold_err || pc_restore) error = 1'b0;
            if (n == halt_delay + 1) begin
                halted_a = 1'b1;
                halted_b = 1'b1;
            end
            if (wb_we && first_we_n < 0) first_we_n = n;
            if (!recovering) begin
                done = 1'b1;
                error = 1'b0;
                halted_a = 1'b0;
                halted_b = 1'b0;
            end
        end
        end_n = n;
    endtask

    task automatic verify_writes(input string tag, input int exp_count);
        check({tag, "_write_count"}, 64'(wr_addr_q.size()), 64'(exp_count));
        for (int i = 0; i < wr_addr_q.size() && i < exp_count; i++) begin
            check({tag, "_addr"}, 64'(wr_addr_q[i]), 64'(i));
            check({tag, "_data"}, 64'(wr_data_q[i]), 64'(shadow[i]));
        end
    endtask

    initial begin
        int exp_cnt;
        int end_n;
        int first_we;
        int delay;
        int n;

        // Reset state
        do_reset();
        check("rst_halt", 64'(halt), 64'(0));
        check("rst_we", 64'(wb_we), 64'(0));
        check("rst_pc", 64'(pc_restore), 64'(0));
        check("rst_fatal", 64'(fatal), 64'(0));
        check("rst_cnt", 64'(recovery_cnt), 64'(0));
        check("rst_raddr", 64'(rf_raddr), 64'(0));
        check("rst_waddr", 64'(wb_addr), 64'(0));
        check("rst_wdata", 64'(wb_data), 64'(0));
        check("rst_recovering", 64'(recovering), 64'(0));
        exp_cnt = 0;

        // Nominal recovery: halted two cycles after the error, patterned shadow data
        fill_shadow(1'b1);
        run_recovery(1, 1'b0, end_n, first_we);
        exp_cnt++;
        check("nom_duration", 64'(end_n), 64'(2 + DEPTH + 1 + 1 + 1));
        check("nom_first_we", 64'(first_we), 64'(2 + 2));
        verify_writes("nom", DEPTH);
        check("nom_pc_pulses", 64'(pc_pulses), 64'(1));
        check("nom_cnt", 64'(recovery_cnt), 64'(exp_cnt));
        check("nom_halt_released", 64'(halt), 64'(0));
        check("nom_fatal", 64'(fatal), 64'(0));

        // Cores already halted, error held through the whole restore
        fill_shadow(1'b0);
        run_recovery(0, 1'b1, end_n, first_we);
        exp_cnt++;
        check("held_latency", 64'(first_we), 64'(3));
        check("held_duration", 64'(end_n), 64'(1 + DEPTH + 1 + 1 + 1));
        verify_writes("held", DEPTH);
        check("held_pc_pulses", 64'(pc_pulses), 64'(1));
        check("held_cnt", 64'(recovery_cnt), 64'(exp_cnt));

        // Random halt delay inside the timeout window
        fill_shadow(1'b0);
        delay = int'($urandom_range(2, HT - 2));
        run_recovery(delay, 1'b0, end_n, first_we);
        exp_cnt++;
        check("rand_duration", 64'(end_n), 64'(delay + 1 + DEPTH + 1 + 1 + 1));
        verify_writes("rand", DEPTH);
        check("rand_cnt", 64'(recovery_cnt), 64'(exp_cnt));

        // Retry budget exhausted: next error goes straight to FATAL
        clear_log();
        error = 1'b1;
        tick();
        error = 1'b0;
        check("retry_fatal", 64'(fatal), 64'(exp_cnt >= MR));
        check("retry_halt", 64'(halt), 64'(1));
        check("retry_recovering", 64'(recovering), 64'(0));
        check("retry_cnt", 64'(recovery_cnt), 64'(MR));
        for (int i = 0; i < 20; i++) begin
            error    = 1'($urandom);
            halted_a = 1'($urandom);
            halted_b = 1'($urandom);
            tick();
        end
        error = 1'b0;
        check("fatal_sticky", 64'(fatal), 64'(1));
        check("fatal_halt", 64'(halt), 64'(1));
        check("fatal_pc", 64'(pc_restore), 64'(0));
        check("fatal_writes", 64'(wr_addr_q.size()), 64'(0));
        check("fatal_pc_pulses", 64'(pc_pulses), 64'(0));

        // Reset leaves FATAL and clears the counter
        do_reset();
        exp_cnt = 0;
        check("fatal_rst_fatal", 64'(fatal), 64'(0));
        check("fatal_rst_cnt", 64'(recovery_cnt), 64'(exp_cnt));

        // Halt timeout: core B never stalls
        clear_log();
        halted_a = 1'b1;
        halted_b = 1'b0;
        error = 1'b1;
        n = 0;
        while (!fatal && n < BUDGET) begin
            tick();
            n++;
            error = 1'b0;
        end
        check("tmo_cycles", 64'(n), 64'(HT + 1));
        check("tmo_fatal", 64'(fatal), 64'(1));
        check("tmo_halt", 64'(halt), 64'(1));
        check("tmo_writes", 64'(wr_addr_q.size()), 64'(0));

        // Reset on restore cycle 10 aborts without writing address 10
        do_reset();
        fill_shadow(1'b0);
        clear_log();
        error = 1'b1;
        halted_a = 1'b1;
        halted_b = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            error = 1'b0;
        end
        rst = 1'b1;
        tick();
        check("abort_halt", 64'(halt), 64'(0));
        check("abort_we", 64'(wb_we), 64'(0));
        check("abort_recovering", 64'(recovering), 64'(0));
        check("abort_raddr", 64'(rf_raddr), 64'(0));
        check("abort_wdata", 64'(wb_data), 64'(0));
        rst = 1'b0;
        halted_a = 1'b0;
        halted_b = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        verify_writes("abort", 10);
        check("abort_idle", 64'(recovering), 64'(0));
        check("abort_pc_pulses", 64'(pc_pulses), 64'(0));
        check("abort_cnt", 64'(recovery_cnt), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
